// File: rtl/fpu_issue_sched.sv
// Round-robin issue scheduler sharing one pipelined FPU across NUM_REQ requesters,
// with FCR compare hazard blocking and a flushable shadow pipeline. Optional: FPU_ISSUE_SCHED_PERF_EN.

module fpu_issue_sched_lane #(
    parameter int FPU_LAT      = 2,
    parameter int LG_FCR_WIDTH = 4
) (
    input  logic                                 req_val,
    input  logic                                 req_is_cmp,
    input  logic [LG_FCR_WIDTH-1:0]              req_fcr_ptr,
    input  logic [FPU_LAT:0]                     vld_pipe,
    input  logic [FPU_LAT:0]                     cmp_pipe,
    input  logic [FPU_LAT:0][LG_FCR_WIDTH-1:0]   fcr_pipe,
    output logic                                 elig
);
    logic [FPU_LAT:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k <= FPU_LAT; k++)
            hit[k] = vld_pipe[k] & cmp_pipe[k] & (fcr_pipe[k] == req_fcr_ptr);
    end

    // Only compares wait on an older live compare to the same FCR.
    assign elig = req_val & ~(req_is_cmp & (|hit));
endmodule

module fpu_issue_sched #(
    parameter int NUM_REQ      = 2,
    parameter int PAYLOAD_W    = 160,
    parameter int LG_FCR_WIDTH = 4,
    parameter int FPU_LAT      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_val,
    output logic [NUM_REQ-1:0]                req_rdy,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]      req_payload,
    input  logic [NUM_REQ-1:0]                req_is_cmp,
    input  logic [NUM_REQ*LG_FCR_WIDTH-1:0]   req_fcr_ptr,
    input  logic                              issue_hold,
    input  logic                              flush,
    output logic                              fpu_start,
    output logic [PAYLOAD_W-1:0]              fpu_payload,
    input  logic                              fpu_val_in,
    input  logic                              fpu_cmp_val_in,
    output logic                              wb_val,
    output logic                              cmp_wb_val,
    output logic                              busy
`ifdef FPU_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_issue_cnt,
    output logic [31:0]                       perf_haz_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][PAYLOAD_W-1:0]      pay_arr;
    logic [NUM_REQ-1:0][LG_FCR_WIDTH-1:0]   fcr_arr;
    assign pay_arr = req_payload;
    assign fcr_arr = req_fcr_ptr;

    // Index FPU_LAT is the issue stage; indices FPU_LAT-1..0 are the shadow stages.
    logic [FPU_LAT:0]                       vld_pipe;
    logic [FPU_LAT:0]                       cmp_pipe;
    logic [FPU_LAT:0][LG_FCR_WIDTH-1:0]     fcr_pipe;
    logic [PAYLOAD_W-1:0]                   iss_payload;
    logic [PTR_W-1:0]                       rr_ptr;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] hi_elig;
    logic [NUM_REQ-1:0] sel;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   rr_next;
    logic               gnt_fire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fpu_issue_sched_lane #(
            .FPU_LAT      (FPU_LAT),
            .LG_FCR_WIDTH (LG_FCR_WIDTH)
        ) u_lane (
            .req_val     (req_val[i]),
            .req_is_cmp  (req_is_cmp[i]),
            .req_fcr_ptr (fcr_arr[i]),
            .vld_pipe    (vld_pipe),
            .cmp_pipe    (cmp_pipe),
            .fcr_pipe    (fcr_pipe),
            .elig        (elig[i])
        );
    end

    // Prefer eligible lanes at or above rr_ptr; otherwise wrap to the lowest eligible lane.
    always_comb begin
        hi_elig = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            hi_elig[i] = elig[i] & (PTR_W'(i) >= rr_ptr);
        sel = (|hi_elig) ? hi_elig : elig;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (sel[i]) gnt_idx = PTR_W'(i);
    end

    assign gnt_fire = (|sel) & ~issue_hold & ~flush & ~reset;
    assign req_rdy  = gnt_fire ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rr_next  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            vld_pipe    <= '0;
            cmp_pipe    <= '0;
            fcr_pipe    <= '0;
            iss_payload <= '0;
        end else begin
            vld_pipe <= flush ? '0 : {gnt_fire, vld_pipe[FPU_LAT:1]};
            cmp_pipe <= {req_is_cmp[gnt_idx], cmp_pipe[FPU_LAT:1]};
            fcr_pipe <= {fcr_arr[gnt_idx], fcr_pipe[FPU_LAT:1]};
            if (gnt_fire) begin
                iss_payload <= pay_arr[gnt_idx];
                rr_ptr      <= rr_next;
            end
        end
    end

    assign fpu_start   = vld_pipe[FPU_LAT];
    assign fpu_payload = iss_payload;
    assign wb_val      = fpu_val_in & vld_pipe[0] & ~flush;
    assign cmp_wb_val  = fpu_cmp_val_in & vld_pipe[0] & ~flush;
    assign busy        = |vld_pipe;

`ifdef FPU_ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_cnt     <= '0;
            perf_haz_stall_cnt <= '0;
        end else begin
            if (fpu_start && perf_issue_cnt != 32'hFFFF_FFFF)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((|req_val) && !gnt_fire && !issue_hold && !flush &&
                perf_haz_stall_cnt != 32'hFFFF_FFFF)
                perf_haz_stall_cnt <= perf_haz_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
